sdram_cmd_arbiter: RTL

Arbitrates and sequences the single SDRAM burst-command port between three requesters:
- video refill (32-byte read into the video FIFO),
- cache line write-back (256-byte write),
- cache line fill (256-byte read).

It sits in the SDRAM clock domain between the cache controller / video FIFO and the 16-bit SDRAM controller. It owns the video scan address counter and the data-routing flag that tells the datapath whether read beats go to the cache or to the video FIFO.

---
 rtl/sdram_cmd_arbiter_if.sv | 31 +++
 rtl/sdram_cmd_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter_if.sv
// sdram_cmd_arbiter_if: requester and SDRAM-controller signals of the burst
// command arbiter. The slave modport is the arbiter's view. The master modport
// is the surrounding logic: cache, video FIFO and SDRAM controller.
interface sdram_cmd_arbiter_if;
  logic        vid_req;
  logic        wb_req;
  logic        fill_req;
  logic [11:0] wb_addr;
  logic [11:0] fill_addr;
  logic        vid_restart;
  logic [1:0]  sdr_cmd;
  logic [17:0] sdr_addr;
  logic [1:0]  sdr_ack;
  logic        sdr_rd_valid;
  logic        sdr_wr_valid;
  logic        route_cache;
  logic        vid_beat;
  logic        busy;

  modport slave (
    input  vid_req, wb_req, fill_req, wb_addr, fill_addr, vid_restart,
           sdr_ack, sdr_rd_valid, sdr_wr_valid,
    output sdr_cmd, sdr_addr, route_cache, vid_beat, busy
  );

  modport master (
    output vid_req, wb_req, fill_req, wb_addr, fill_addr, vid_restart,
           sdr_ack, sdr_rd_valid, sdr_wr_valid,
    input  sdr_cmd, sdr_addr, route_cache, vid_beat, busy
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares the single SDRAM burst-command port between three
// requesters: video refill, cache write-back and cache fill. It also owns the
// video scan block index and the flag that routes read beats to cache or video.
// Optional macro ARB_FAIR_EN: after FAIR_LIMIT video grants made while the
// cache is waiting, the next grant goes to the cache.
module sdram_cmd_arbiter #(
  parameter logic [2:0] VID_BASE   = 3'b100,
  parameter int         VID_LAST   = 1199,
  parameter int         VID_BEATS  = 16,
  parameter int         LINE_BEATS = 128,
  parameter int         FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  sdram_cmd_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  localparam logic [1:0]  CMD_NOP  = 2'b00;
  localparam logic [1:0]  CMD_WR   = 2'b01;
  localparam logic [1:0]  CMD_RDV  = 2'b10;
  localparam logic [1:0]  CMD_RDL  = 2'b11;
  localparam logic [11:0] IDX_LAST = 12'(VID_LAST);
  localparam logic [6:0]  VID_END  = 7'(VID_BEATS - 1);
  localparam logic [6:0]  LINE_END = 7'(LINE_BEATS - 1);

  // Reject parameter sets that do not fit the fixed counter widths.
  if (VID_LAST < 1 || VID_LAST > 4095 || VID_BEATS < 1 || VID_BEATS > 128 ||
      LINE_BEATS < 1 || LINE_BEATS > 128 || FAIR_LIMIT < 1 || FAIR_LIMIT > 255)
  begin : g_bad_param
    $error("sdram_cmd_arbiter: parameter out of range");
  end

  state_t      state, state_n;
  logic [1:0]  gnt, gnt_n;       // granted command code, held through BURST
  logic [17:0] addr_q, addr_n;
  logic        route_q, route_n;
  logic [6:0]  beat_q, beat_n;
  logic [11:0] idx_q, idx_n, idx_use;
  logic        pend_q, pend_n;   // frame restart waiting for the next IDLE
  logic        cache_req, cache_first, beat_in;

`ifdef ARB_FAIR_EN
  localparam int FW = $clog2(FAIR_LIMIT + 1);
  logic [FW-1:0] fair_q, fair_n;
`endif

  assign bus.sdr_cmd     = (state == ISSUE) ? gnt : CMD_NOP;
  assign bus.sdr_addr    = addr_q;
  assign bus.route_cache = route_q;
  assign bus.busy        = (state != IDLE);
  assign bus.vid_beat    = bus.sdr_rd_valid & (state == BURST) & ~route_q;

  // Next-state logic: grant selection, ack wait, beat counting and index upkeep.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    addr_n    = addr_q;
    route_n   = route_q;
    beat_n    = beat_q;
    idx_n     = idx_q;
    pend_n    = pend_q | bus.vid_restart;
    // A restart is applied only while idle, so an in-flight burst keeps its target.
    idx_use   = (pend_q | bus.vid_restart) ? 12'd0 : idx_q;
    cache_req = bus.wb_req | bus.fill_req;
    beat_in   = (gnt == CMD_WR) ? bus.sdr_wr_valid : bus.sdr_rd_valid;
`ifdef ARB_FAIR_EN
    fair_n      = fair_q;
    cache_first = cache_req && (fair_q >= FW'(FAIR_LIMIT));
`else
    cache_first = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        idx_n  = idx_use;
        pend_n = 1'b0;
        if (bus.vid_req && !cache_first) begin
          gnt_n   = CMD_RDV;
          addr_n  = {VID_BASE, idx_use, 3'b000};
          route_n = 1'b0;
          state_n = ISSUE;
`ifdef ARB_FAIR_EN
          if (cache_req && (fair_q < FW'(FAIR_LIMIT))) fair_n = fair_q + 1'b1;
`endif
        end else if (bus.wb_req) begin
          gnt_n   = CMD_WR;
          addr_n  = {bus.wb_addr, 6'b0};
          route_n = 1'b1;
          state_n = ISSUE;
`ifdef ARB_FAIR_EN
          fair_n  = '0;
`endif
        end else if (bus.fill_req) begin
          gnt_n   = CMD_RDL;
          addr_n  = {bus.fill_addr, 6'b0};
          route_n = 1'b1;
          state_n = ISSUE;
`ifdef ARB_FAIR_EN
          fair_n  = '0;
`endif
        end
      end
      ISSUE: begin
        // Only an echo of the held code counts; other nonzero codes are ignored.
        if (bus.sdr_ack == gnt) begin
          state_n = BURST;
          beat_n  = 7'd0;
          if (gnt == CMD_RDV) idx_n = (idx_q == IDX_LAST) ? 12'd0 : idx_q + 12'd1;
        end
      end
      BURST: begin
        if (beat_in) begin
          if (beat_q == ((gnt == CMD_RDV) ? VID_END : LINE_END)) state_n = IDLE;
          else beat_n = beat_q + 7'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= CMD_NOP;
      addr_q  <= '0;
      route_q <= 1'b0;
      beat_q  <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      addr_q  <= addr_n;
      route_q <= route_n;
      beat_q  <= beat_n;
      idx_q   <= idx_n;
      pend_q  <= pend_n;
    end
  end

`ifdef ARB_FAIR_EN
  // Counts consecutive video grants made while the cache is waiting.
  always_ff @(posedge clk) begin
    if (rst) fair_q <= '0;
    else     fair_q <= fair_n;
  end
`endif
endmodule
